// File: rtl/hub75_bcm_driver_pkg.sv
// Shared definitions for the HUB75 BCM scan engine.
// - state_t   : scan FSM states
// - CH_*      : channel lane positions inside a pixel word {R0,G0,B0,R1,G1,B1}
// - clog2     : ceiling log2 usable in constant expressions
// - width_of  : clog2 clamped to at least 1 bit, for counter/address widths
package hub75_bcm_driver_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_DISPLAY,
        S_NEXT
    } state_t;

    // Lane index of each colour channel; lane n occupies bits [n*BIT_DEPTH +: BIT_DEPTH].
    localparam int unsigned CH_B1 = 0;
    localparam int unsigned CH_G1 = 1;
    localparam int unsigned CH_R1 = 2;
    localparam int unsigned CH_B0 = 3;
    localparam int unsigned CH_G0 = 4;
    localparam int unsigned CH_R0 = 5;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned width_of(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/hub75_bcm_driver_if.sv
// Frame-memory read port between the scan engine and the banked frame store.
// - addr  : pixel address {row, col}
// - frame : frame bank being displayed
// - rd    : one-clock read strobe
// - rdata : pixel word {R0,G0,B0,R1,G1,B1}, valid one clock after rd
// master = scan engine, slave = frame memory.
interface hub75_bcm_driver_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned FW = 2,
    parameter int unsigned DW = 24
);
    logic [AW-1:0] addr;
    logic [FW-1:0] frame;
    logic          rd;
    logic [DW-1:0] rdata;

    modport master (output addr, output frame, output rd, input rdata);
    modport slave  (input addr, input frame, input rd, output rdata);
endinterface

// File: rtl/hub75_bcm_driver_pix_tick_gen.sv
// Pixel tick generator: one-clock tick every CLK_DIV clocks while en is high.
// - clk, rst : clock, asynchronous active-low reset
// - en       : run; low holds the divider at zero so the next run starts a full period later
// - tick     : one-clock enable pulse
module pix_tick_gen
    import hub75_bcm_driver_pkg::*;
#(
    parameter int unsigned CLK_DIV = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int unsigned CNT_W = width_of(CLK_DIV);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 half-scan panel driver with BIT_DEPTH-plane binary-code modulation.
// - clk, rst      : clock, asynchronous active-low reset
// - enable        : scan while high; a drop takes effect after the current plane
// - frame_sel     : requested frame bank, adopted only at frame boundaries
// - mem           : frame-memory read port (master side)
// - LP_CLK, LATCH : panel shift clock and latch
// - NOE           : output disable, 1 = blanked
// - ROW           : row-pair address
// - RGB0, RGB1    : upper/lower half colour bits {R,G,B}
// - frame_done    : one-clock pulse when the last plane of the last row finishes
// - busy          : high whenever the FSM is not idle
module hub75_bcm_driver
    import hub75_bcm_driver_pkg::*;
#(
    parameter int unsigned NUM_COLS   = 64,
    parameter int unsigned NUM_ROWS   = 64,
    parameter int unsigned BIT_DEPTH  = 4,
    parameter int unsigned NUM_FRAMES = 4,
    parameter int unsigned CLK_DIV    = 3,
    parameter int unsigned BASE_ON    = 16,
    localparam int unsigned RW = width_of(NUM_ROWS / 2),
    localparam int unsigned CW = width_of(NUM_COLS),
    localparam int unsigned AW = RW + CW,
    localparam int unsigned FW = width_of(NUM_FRAMES),
    localparam int unsigned DW = 6 * BIT_DEPTH,
    localparam int unsigned PW = clog2(BIT_DEPTH) + 1,
    localparam int unsigned OW = clog2(BASE_ON << (BIT_DEPTH - 1)) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [FW-1:0]        frame_sel,
    hub75_bcm_driver_if.master   mem,
    output logic                 LP_CLK,
    output logic                 LATCH,
    output logic                 NOE,
    output logic [RW-1:0]        ROW,
    output logic [2:0]           RGB0,
    output logic [2:0]           RGB1,
    output logic                 frame_done,
    output logic                 busy
);
    state_t           state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [RW-1:0]    row_nxt;
    logic [PW-1:0]    plane;
    logic [OW-1:0]    on_cnt;
    logic [OW-1:0]    on_last;
    logic             phase;      // 0: next tick is tick A (data), 1: tick B (clock rise)
    logic             plane_last;
    logic             row_last;
    logic             tick;
    logic             tick_run;
    logic [AW-1:0]    addr_q;
    logic [FW-1:0]    frame_q;
    logic             rd_q;
    logic [DW-1:0]    rdata;
    logic [BIT_DEPTH-1:0] lane;
    logic [5:0]       plane_bits;

    assign mem.addr  = addr_q;
    assign mem.frame = frame_q;
    assign mem.rd    = rd_q;
    assign rdata     = mem.rdata;

    // The divider only runs in the tick-paced states, so every SHIFT entry
    // starts a full CLK_DIV period after its mem_rd and the first word is ready.
    assign tick_run = (state == S_SHIFT) || (state == S_BLANK) || (state == S_LATCH);

    pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_run),
        .tick (tick)
    );

    always_comb begin
        plane_last = (plane == PW'(BIT_DEPTH - 1));
        row_last   = (row == RW'(NUM_ROWS / 2 - 1));
        row_nxt    = row;
        if (plane_last) begin
            row_nxt = row_last ? '0 : row + 1'b1;
        end
        on_last = (OW'(BASE_ON) << plane) - OW'(1);
    end

    // Shift each channel lane down by the plane so bit 0 is the wanted bit.
    always_comb begin
        lane       = '0;
        plane_bits = '0;
        for (int unsigned ch = 0; ch < 6; ch++) begin
            lane           = rdata[ch * BIT_DEPTH +: BIT_DEPTH] >> plane;
            plane_bits[ch] = lane[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            LP_CLK     <= 1'b0;
            LATCH      <= 1'b0;
            NOE        <= 1'b1;
            ROW        <= '0;
            RGB0       <= '0;
            RGB1       <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            frame_q    <= '0;
            row        <= '0;
            col        <= '0;
            plane      <= '0;
            phase      <= 1'b0;
            on_cnt     <= '0;
        end else begin
            rd_q       <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    NOE <= 1'b1;
                    if (enable) begin
                        frame_q <= frame_sel;
                        row     <= '0;
                        plane   <= '0;
                        col     <= '0;
                        phase   <= 1'b0;
                        addr_q  <= '0;
                        rd_q    <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            LP_CLK <= 1'b0;
                            RGB0   <= {plane_bits[CH_R0], plane_bits[CH_G0], plane_bits[CH_B0]};
                            RGB1   <= {plane_bits[CH_R1], plane_bits[CH_G1], plane_bits[CH_B1]};
                            phase  <= 1'b1;
                        end else begin
                            LP_CLK <= 1'b1;
                            phase  <= 1'b0;
                            if (col == CW'(NUM_COLS - 1)) begin
                                col   <= '0;
                                state <= S_BLANK;
                            end else begin
                                // Prefetch the next column while this one is clocked in.
                                col    <= col + 1'b1;
                                addr_q <= {row, col + 1'b1};
                                rd_q   <= 1'b1;
                            end
                        end
                    end
                end
                S_BLANK: begin
                    if (tick) begin
                        LP_CLK <= 1'b0;
                        ROW    <= row;
                        LATCH  <= 1'b1;
                        state  <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (tick) begin
                        LATCH  <= 1'b0;
                        NOE    <= 1'b0;
                        on_cnt <= '0;
                        state  <= S_DISPLAY;
                    end
                end
                S_DISPLAY: begin
                    if (on_cnt == on_last) begin
                        NOE   <= 1'b1;
                        state <= S_NEXT;
                    end else begin
                        on_cnt <= on_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    row   <= row_nxt;
                    plane <= plane_last ? '0 : plane + 1'b1;
                    col   <= '0;
                    phase <= 1'b0;
                    if (plane_last && row_last) begin
                        frame_done <= 1'b1;
                        frame_q    <= frame_sel;
                    end
                    if (enable) begin
                        addr_q <= {row_nxt, {CW{1'b0}}};
                        rd_q   <= 1'b1;
                        state  <= S_SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed self-checking bench for hub75_bcm_driver on a 4x4 panel, 2-bit BCM,
// two frame banks, CLK_DIV=2, BASE_ON=4.
module tb_hub75_bcm_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [0:0] frame_sel = 1'b0;
    logic       LP_CLK, LATCH, NOE;
    logic [0:0] ROW;
    logic [2:0] RGB0, RGB1;
    logic       frame_done, busy;

    int errors = 0;
    int checks = 0;
    int fd_count = 0;
    logic lp_prev = 1'b0;

    logic [11:0] base [8] = '{12'h0AC5, 12'h53A, 12'hF0F, 12'h0F0,
                              12'hA5A,  12'h333, 12'hCCC, 12'h6B9};

    hub75_bcm_driver_if #(.AW(3), .FW(1), .DW(12)) mem_if ();

    hub75_bcm_driver #(
        .NUM_COLS(4), .NUM_ROWS(4), .BIT_DEPTH(2),
        .NUM_FRAMES(2), .CLK_DIV(2), .BASE_ON(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_sel(frame_sel), .mem(mem_if.master),
        .LP_CLK(LP_CLK), .LATCH(LATCH), .NOE(NOE), .ROW(ROW), .RGB0(RGB0), .RGB1(RGB1),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bank 1 holds the bitwise inverse of bank 0.
    function automatic logic [11:0] word_of(input logic fr, input int a);
        logic [11:0] w;
        w = base[a];
        return fr ? ~w : w;
    endfunction

    // Word layout {R0[11:10],G0[9:8],B0[7:6],R1[5:4],G1[3:2],B1[1:0]}.
    function automatic logic [2:0] exp_rgb(input logic [11:0] w, input int p, input bit upper);
        int o;
        o = upper ? 6 : 0;
        return {w[o + 4 + p], w[o + 2 + p], w[o + p]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial mem_if.rdata = '0;
    always @(posedge clk) if (mem_if.rd) mem_if.rdata <= word_of(mem_if.frame, int'(mem_if.addr));

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    always @(negedge clk) begin
        if ((LP_CLK !== lp_prev) || (LATCH === 1'b1)) chk("noe_blank", NOE, 1);
        lp_prev = LP_CLK;
    end

    // Follows one row-plane from its SHIFT entry to the end of DISPLAY.
    task automatic observe(input int r, input int p, input logic fr, input bit drop_en);
        int rises = 0, rds = 0, low = 0, latch_cyc = 0;
        bit prev_lp;
        bit done = 0;
        logic [11:0] w;
        prev_lp = LP_CLK;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(posedge clk); #1;
            if (mem_if.rd === 1'b1) begin
                chk("rd_addr", mem_if.addr, r * 4 + rds);
                rds++;
            end
            if (LP_CLK === 1'b1 && prev_lp === 1'b0) begin
                w = word_of(fr, r * 4 + rises);
                chk("rgb0", RGB0, exp_rgb(w, p, 1));
                chk("rgb1", RGB1, exp_rgb(w, p, 0));
                chk("mem_frame", mem_if.frame, fr);
                rises++;
            end
            if (LATCH === 1'b1) begin
                if (latch_cyc == 0) begin
                    chk("lp_rises_at_latch", rises, 4);
                    chk("row_at_latch", ROW, r);
                end
                latch_cyc++;
            end
            if (NOE === 1'b0) begin
                low++;
                if (drop_en) enable = 1'b0;
            end else if (low > 0) begin
                done = 1;
            end
            prev_lp = LP_CLK;
        end
        chk("plane_done", done, 1);
        chk("latch_width", latch_cyc, 2);
        chk("noe_width", low, 4 << p);
        chk("rd_count", rds, 4);
    endtask

    initial begin
        int rises;
        int rds;
        bit hit;

        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_noe", NOE, 1);
        chk("rst_lp", LP_CLK, 0);
        chk("rst_latch", LATCH, 0);
        chk("rst_row", ROW, 0);
        chk("rst_rgb0", RGB0, 0);
        chk("rst_rgb1", RGB1, 0);
        chk("rst_rd", mem_if.rd, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", mem_if.addr, 0);
        chk("rst_frame", mem_if.frame, 0);

        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_noe", NOE, 1);

        // Frame 0, bank switch requested mid-frame.
        @(negedge clk);
        enable = 1'b1;
        observe(0, 0, 1'b0, 0);
        chk("busy_scan", busy, 1);
        observe(0, 1, 1'b0, 0);
        frame_sel = 1'b1;
        observe(1, 0, 1'b0, 0);
        observe(1, 1, 1'b0, 0);
        chk("fd_before_wrap", fd_count, 0);
        chk("frame_held", mem_if.frame, 0);
        observe(0, 0, 1'b1, 0);
        chk("fd_after_wrap", fd_count, 1);
        observe(0, 1, 1'b1, 0);

        // enable drop during plane-0 display of row 1.
        observe(1, 0, 1'b1, 1);
        @(posedge clk); #1;
        chk("stop_busy", busy, 0);
        chk("stop_noe", NOE, 1);
        chk("stop_row_hold", ROW, 1);
        rises = 0;
        rds = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (LP_CLK === 1'b1) rises++;
            if (mem_if.rd === 1'b1) rds++;
        end
        chk("stop_no_lp", rises, 0);
        chk("stop_no_rd", rds, 0);

        // Restart from row 0 with bank 0.
        frame_sel = 1'b0;
        enable = 1'b1;
        observe(0, 0, 1'b0, 0);

        // Asynchronous reset in the middle of DISPLAY.
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk); #1;
            if (NOE === 1'b0) hit = 1;
        end
        chk("reach_display", hit, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_noe", NOE, 1);
        chk("arst_latch", LATCH, 0);
        chk("arst_lp", LP_CLK, 0);
        chk("arst_busy", busy, 0);
        chk("arst_row", ROW, 0);
        frame_sel = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        observe(0, 0, 1'b1, 0);

        enable = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
